// File: rtl/deserializador_alineador.sv
// Serial-to-10-bit deserializer with K28.5 comma alignment and lock tracking.
// Define DESER_LOSS_CNT_EN to add the saturating lossCount[7:0] output.
module deserializador_alineador #(
  parameter logic [9:0] COMMA       = 10'h17C,
  parameter int         LOCK_COMMAS = 3,
  parameter int         LOSS_COUNT  = 4
) (
  input  logic       clkRx,
  input  logic       rstN,
  input  logic       dataSync,
  output logic [9:0] dataOut,
  output logic       validOut,
  output logic       isComma,
  output logic       locked
`ifdef DESER_LOSS_CNT_EN
  ,
  output logic [7:0] lossCount
`endif
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_TH = 4'(LOSS_COUNT);

  state_e     state_q, state_d;
  logic [9:0] shift_q, shift_d;
  logic [3:0] phase_q, phase_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [9:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       is_comma_q, is_comma_d;
  logic       locked_q, locked_d;

  logic       comma_hit_s;
  logic       boundary_s;
  logic [3:0] comma_inc_s;
  logic [3:0] err_inc_s;

  // Either running-disparity form of K28.5 marks a symbol boundary.
  function automatic logic is_comma_f(input logic [9:0] sym);
    return (sym == COMMA) || (sym == ~COMMA);
  endfunction

  always_comb begin
    comma_hit_s = is_comma_f(shift_q);
    boundary_s  = (phase_q == 4'd0) && (state_q != ST_SEARCH);
    shift_d     = {dataSync, shift_q[9:1]};
    comma_inc_s = (comma_cnt_q >= LOCK_TH) ? comma_cnt_q : comma_cnt_q + 4'd1;
    err_inc_s   = (err_cnt_q >= LOSS_TH) ? err_cnt_q : err_cnt_q + 4'd1;
  end

  always_ff @(posedge clkRx or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    phase_d     = (phase_q >= 4'd9) ? 4'd0 : phase_q + 4'd1;
    case (state_q)
      ST_SEARCH: begin
        // The detect cycle acts as phase 0, so the next boundary is 10 cycles on.
        if (comma_hit_s) begin
          phase_d     = 4'd1;
          comma_cnt_d = 4'd1;
          state_d     = ST_CHECK;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_CHECK: begin
        if (boundary_s) begin
          if (comma_hit_s) begin
            comma_cnt_d = comma_inc_s;
            if (comma_inc_s >= LOCK_TH) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = ST_SEARCH;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_LOCKED: begin
        if (comma_hit_s && boundary_s) begin
          err_cnt_d = 4'd0;
        end else if (comma_hit_s) begin
          if (err_inc_s >= LOSS_TH) begin
            err_cnt_d   = 4'd0;
            comma_cnt_d = 4'd0;
            state_d     = ST_SEARCH;
          end else begin
            err_cnt_d = err_inc_s;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
      default: begin
        state_d     = ST_SEARCH;
        comma_cnt_d = 4'd0;
        err_cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    data_d     = data_q;
    is_comma_d = is_comma_q;
    valid_d    = 1'b0;
    if ((state_q == ST_LOCKED) && boundary_s) begin
      data_d     = shift_q;
      is_comma_d = comma_hit_s;
      valid_d    = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clkRx or negedge rstN) begin
    if (!rstN) begin
      shift_q     <= 10'd0;
      phase_q     <= 4'd0;
      comma_cnt_q <= 4'd0;
      err_cnt_q   <= 4'd0;
      data_q      <= 10'd0;
      valid_q     <= 1'b0;
      is_comma_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      is_comma_q  <= is_comma_d;
      locked_q    <= locked_d;
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign isComma  = is_comma_q;
  assign locked   = locked_q;

`ifdef DESER_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Counts LOCKED->SEARCH drops; only rstN clears it.
  always_comb begin
    if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
  end

  always_ff @(posedge clkRx or negedge rstN) begin
    if (!rstN) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lossCount = loss_cnt_q;
`endif

endmodule

// File: doc/deserializador_alineador.md
Name: deserializador_alineador

Overview:
Receive-side stage directly downstream of the 2-FF serial-bit synchronizer. It consumes the synchronized serial bit stream, one bit per clkRx cycle, and shifts it into 10-bit symbols. It finds the symbol boundary by detecting the 8b/10b K28.5 comma, declares lock after repeated aligned commas, then presents aligned 10-bit words with a one-cycle valid strobe to the 8b/10b decoder.

Parameters:
COMMA, 10'h17C, K28.5 RD- pattern as stored in the shift register (bit0 = first received bit); its complement 10'h283 (RD+) also matches.
LOCK_COMMAS, 3, consecutive aligned commas needed to enter LOCKED (range 1..15).
LOSS_COUNT, 4, misaligned commas while LOCKED that force a return to SEARCH (range 1..15).

Ports:
clkRx  input  1  receiver clock; all state changes on its posedge.
rstN  input  1  reset, asynchronous, active-low.
dataSync  input  1  synchronized serial bit, one bit per clkRx cycle.
dataOut  output  10  aligned symbol, bit0 = first received bit.
validOut  output  1  one-cycle strobe; dataOut is valid while high.
isComma  output  1  qualifies dataOut as a comma (either polarity); meaningful only with validOut.
locked  output  1  high while the state is LOCKED.

Behaviour:
- Interface: one clock, clkRx; reset rstN is asynchronous and active-low.
- Reset (rstN low, any time, including mid-word): shiftReg=0, phaseCnt=0, commaCnt=0, errCnt=0, state=SEARCH. Outputs: dataOut=0, validOut=0, isComma=0, locked=0. All outputs are registered.
- Shift register: every cycle, shiftReg <= {dataSync, shiftReg[9:1]}. After 10 cycles, the first bit received sits in bit0.
- commaHit (combinational on the registered shiftReg): shiftReg==COMMA or shiftReg==~COMMA.
- phaseCnt: 0..9, increments every cycle and wraps 9->0.
- Boundary cycle: a cycle with phaseCnt==0 in CHECK or LOCKED. At a boundary, shiftReg holds one aligned symbol.
- SEARCH:
  - On commaHit: phaseCnt<=1, commaCnt<=1, go to CHECK. The next boundary is therefore 10 cycles after the detect cycle.
  - Otherwise stay in SEARCH.
  - No validOut is produced in SEARCH.
- CHECK:
  - At a boundary with commaHit: commaCnt++. When commaCnt reaches LOCK_COMMAS, go to LOCKED and set locked=1 in the same edge.
  - At a boundary without commaHit: go to SEARCH, commaCnt<=0.
  - commaHit at a non-boundary cycle is ignored.
  - No validOut is produced in CHECK.
- LOCKED:
  - At each boundary: dataOut<=shiftReg, isComma<=commaHit, validOut<=1. These become visible the cycle after the boundary.
  - validOut is otherwise 0, giving exactly one pulse per 10 cycles.
  - commaHit at a boundary clears errCnt.
  - commaHit at a non-boundary cycle increments errCnt. When errCnt reaches LOSS_COUNT, go to SEARCH with locked<=0, errCnt<=0, commaCnt<=0, in the same edge as the final increment.
  - A boundary symbol is still emitted if it coincides with the edge that loses lock; validOut is 0 from then on.
- Latency: last bit of a symbol present on dataSync at edge N -> dataOut/validOut valid after edge N+1.
- Alignment: phase is re-captured only in SEARCH. A realignment therefore always passes through CHECK, so no valid pulses occur during reacquisition.
- Counters saturate at their thresholds and never wrap.

Optional Feature:
DESER_LOSS_CNT_EN: when defined, adds output port lossCount[7:0].
- lossCount increments on every LOCKED->SEARCH transition and saturates at 8'hFF.
- lossCount is cleared only by rstN.
When not defined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Reset: hold rstN=0 while toggling dataSync -> all outputs 0, state SEARCH. Release rstN -> outputs stay 0 until a lock sequence is received.
- Lock acquisition: 7 random bits, then COMMA 10'h17C sent 3 times (bit0 first), then D-symbol 10'h2AA -> locked rises after the 3rd comma's boundary edge. First validOut pulse carries 10'h2AA, isComma=0, one cycle wide. Subsequent pulses are exactly 10 cycles apart.
- Failed acquisition: comma, comma, 10'h155, comma... -> returns to SEARCH after 10'h155. locked stays 0 and validOut never asserts until 3 consecutive aligned commas are seen.
- Polarity: alternate 10'h17C and 10'h283 as the lock sequence -> lock achieved; each comma output shows isComma=1.
- Lock loss: while LOCKED, inject 4 commas shifted by 3 bit positions -> locked falls on the 4th misaligned detection and validOut stops. With DESER_LOSS_CNT_EN defined, lossCount goes 0->1. An aligned comma between misaligned ones resets errCnt, so no loss occurs.
- Async reset mid-word: pull rstN low between edges while LOCKED -> locked, validOut and dataOut go to 0 immediately, without waiting for a clock edge. Reacquisition needs a full SEARCH/CHECK sequence.
